// File: rtl/fir_pkg.sv
// Shared fixed-point definitions for the 64-tap FIR filter and its output stage.
package fir_pkg;

  localparam int unsigned IN_W       = 32;
  localparam int unsigned OUT_W      = 16;
  localparam int unsigned FRAC_SHIFT = 15;

  localparam logic signed [OUT_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [OUT_W-1:0] SAT_MIN = 16'sh8000;

  typedef logic signed [OUT_W-1:0] sample_t;

  typedef struct packed {
    logic    keep;
    sample_t data;
  } stage_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry an extra wrap bit for full/empty.
module fir_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  // A write while full is accepted only when a pop frees the head slot on the same edge.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_rd    = rd_en & ~empty;
    do_wr    = wr_en & (~full | do_rd);
    mem_d    = mem_q;
    if (do_wr) mem_d[wr_ptr_q[AW-1:0]] = wr_data;
    wr_ptr_d = wr_ptr_q + PW'(do_wr);
    rd_ptr_d = rd_ptr_q + PW'(do_rd);
    rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/fir_out_decimator.sv
// FIR output stage: round/saturate Q2.30 to Q1.15, decimate, buffer and hand off.
module fir_out_decimator
  import fir_pkg::*;
#(
  parameter int unsigned DECIM      = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [IN_W-1:0] yin,
  input  logic                   yin_valid,
  input  logic                   clr_flags,
  output sample_t                dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   sat_sticky,
  output logic                   ovf_sticky
);

  localparam int unsigned PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned HI_W = IN_W - OUT_W + 2;
  localparam logic signed [IN_W:0] RND_HALF = (IN_W+1)'(2 ** (FRAC_SHIFT - 1));

  logic [PH_W-1:0]        phase_q, phase_d;
  stage_t                 st1_q, st1_d;
  logic                   sat_q, sat_d;
  logic                   ovf_q, ovf_d;
  logic signed [IN_W:0]   rnd_sum, rnd_shr;
  logic [HI_W-1:0]        hi_bits;
  logic                   sat_c, keep_c;
  sample_t                req_data;
  logic                   fifo_full, fifo_empty, rd_en, wr_drop;

  // Round half-up, then clamp whenever the bits above the Q1.15 sign are not a pure sign extension.
  always_comb begin
    rnd_sum = $signed({yin[IN_W-1], yin}) + RND_HALF;
    rnd_shr = rnd_sum >>> FRAC_SHIFT;
    hi_bits = rnd_shr[IN_W:OUT_W-1];
    sat_c   = !((&hi_bits) || !(|hi_bits));
    if (!sat_c)            req_data = rnd_shr[OUT_W-1:0];
    else if (rnd_shr[IN_W]) req_data = SAT_MIN;
    else                    req_data = SAT_MAX;
  end

  always_comb begin
    keep_c  = yin_valid && (phase_q == '0);
    phase_d = phase_q;
    if (yin_valid) phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + PH_W'(1);

    st1_d.keep = keep_c;
    st1_d.data = keep_c ? req_data : st1_q.data;

    rd_en   = dout_valid & dout_ready;
    wr_drop = st1_q.keep & fifo_full & ~rd_en;
    sat_d   = (keep_c & sat_c) | (sat_q & ~clr_flags);
    ovf_d   = wr_drop | (ovf_q & ~clr_flags);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
      st1_q   <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      st1_q   <= st1_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
    end
  end

  fir_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (st1_q.keep),
    .wr_data (st1_q.data),
    .rd_en   (rd_en),
    .rd_data (dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign dout_valid = ~fifo_empty;
  assign sat_sticky = sat_q;
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Directed bench for fir_out_decimator with a scoreboard of expected kept samples.
module tb_fir_out_decimator;

  logic               clk;
  logic               reset;
  logic signed [31:0] yin;
  logic               yin_valid;
  logic               clr_flags;
  logic               dout_ready;

  logic signed [15:0] dout1, dout4;
  logic               dv1, dv4, sat1, sat4, ovf1, ovf4;

  int                 n_tests = 0;
  int                 n_fail  = 0;
  int                 pops    = 0;
  int                 ph      = 0;
  bit                 sel     = 1'b0;
  logic signed [31:0] exp_q[$];

  fir_out_decimator #(.DECIM(1), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .reset(reset), .yin(yin), .yin_valid(yin_valid), .clr_flags(clr_flags),
    .dout(dout1), .dout_valid(dv1), .dout_ready(dout_ready),
    .sat_sticky(sat1), .ovf_sticky(ovf1)
  );

  fir_out_decimator #(.DECIM(4), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .yin(yin), .yin_valid(yin_valid), .clr_flags(clr_flags),
    .dout(dout4), .dout_valid(dv4), .dout_ready(dout_ready),
    .sat_sticky(sat4), .ovf_sticky(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire signed [15:0] mon_dout = sel ? dout4 : dout1;
  wire               mon_dv   = sel ? dv4 : dv1;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference requantiser in plain integer arithmetic (floor division, then clamp).
  function automatic logic signed [31:0] model(input logic signed [31:0] y);
    longint v, r;
    v = longint'(y) + 64'sd16384;
    if (v >= 0) r = v / 32768;
    else        r = -((-v + 32767) / 32768);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return 32'(r);
  endfunction

  // Handshakes are sampled mid-cycle, ahead of the edge on which the pop happens.
  always @(negedge clk) begin
    if (reset && mon_dv && dout_ready) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_extra_output: observed %0d expected none", mon_dout);
      end
      if (exp_q.size() != 0) chk("sb_dout", mon_dout, exp_q.pop_front());
      pops++;
    end
  end

  task automatic step(input logic signed [31:0] y, input logic v, input bit track);
    int decim;
    decim     = sel ? 4 : 1;
    yin       = y;
    yin_valid = v;
    if (v) begin
      if (ph == 0 && track) exp_q.push_back(model(y));
      ph = (ph + 1 == decim) ? 0 : ph + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'sd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    ph    = 0;
    pops  = 0;
    exp_q.delete();
  endtask

  logic signed [31:0] rnd_in  [4];
  logic signed [31:0] rnd_exp [4];

  initial begin
    reset = 1'b0; yin = '0; yin_valid = 1'b0; clr_flags = 1'b0; dout_ready = 1'b0;
    rnd_in  = '{32'sd16384, 32'sd16383, -32'sd16384, -32'sd16385};
    rnd_exp = '{32'sd1, 32'sd0, 32'sd0, -32'sd1};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout1", dout1, 0); chk("rst_dv1", dv1, 0);
    chk("rst_sat1", sat1, 0);   chk("rst_ovf1", ovf1, 0);
    chk("rst_dout4", dout4, 0); chk("rst_dv4", dv4, 0);
    chk("rst_sat4", sat4, 0);   chk("rst_ovf4", ovf4, 0);
    reset = 1'b1;

    // Rounding with two-cycle latency, DECIM=1
    sel = 1'b0; dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(rnd_in[i], 1'b1, 1'b1);
      chk("lat_dv_k", dv1, 0);
      idle(1);
      chk("lat_dv_k1", dv1, 1);
      chk("round_dout", dout1, rnd_exp[i]);
      idle(1);
    end
    chk("round_sat", sat1, 0);
    chk("round_pops", pops, 4);

    // Saturation and sticky clear, including set-wins-over-clear
    step(32'sh7FFF_FFFF, 1'b1, 1'b1);
    chk("sat_set", sat1, 1);
    step(32'sh8000_0000, 1'b1, 1'b1);
    idle(3);
    chk("sat_drained", exp_q.size(), 0);
    clr_flags = 1'b1; idle(1); clr_flags = 1'b0;
    chk("sat_clr", sat1, 0);
    clr_flags = 1'b1; step(32'sh8000_0000, 1'b1, 1'b1); clr_flags = 1'b0;
    chk("sat_set_wins", sat1, 1);
    clr_flags = 1'b1; idle(1); clr_flags = 1'b0;
    chk("sat_clr2", sat1, 0);
    idle(3);

    // Decimation by 4, continuous valid
    do_reset(); sel = 1'b1; dout_ready = 1'b1;
    for (int i = 0; i < 12; i++) step(32'(i * 32768), 1'b1, 1'b1);
    idle(4);
    chk("decim_pops", pops, 3);
    chk("decim_left", exp_q.size(), 0);

    // Decimation with valid gaps
    do_reset(); sel = 1'b1; dout_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(32'(i * 32768), 1'b1, 1'b1);
      step(32'sd12345, 1'b0, 1'b1);
    end
    idle(4);
    chk("gap_pops", pops, 3);
    chk("gap_left", exp_q.size(), 0);

    // Backpressure: six pushes into depth four
    do_reset(); sel = 1'b0; dout_ready = 1'b0;
    for (int i = 1; i <= 6; i++) step(32'(i * 32768), 1'b1, i <= 4);
    idle(2);
    chk("ovf_set", ovf1, 1);
    chk("ovf_dv", dv1, 1);
    chk("ovf_head", dout1, 1);
    dout_ready = 1'b1;
    idle(6);
    chk("ovf_pops", pops, 4);
    chk("ovf_empty", dv1, 0);

    // Write and pop coinciding while full
    do_reset(); sel = 1'b0; dout_ready = 1'b0;
    for (int i = 1; i <= 5; i++) step(32'(i * 32768), 1'b1, 1'b1);
    dout_ready = 1'b1; idle(1); dout_ready = 1'b0;
    idle(1);
    chk("full_rw_ovf", ovf1, 0);
    chk("full_rw_head", dout1, 2);
    dout_ready = 1'b1;
    idle(6);
    chk("full_rw_pops", pops, 5);
    chk("full_rw_left", exp_q.size(), 0);

    // Asynchronous reset with entries queued
    do_reset(); sel = 1'b0; dout_ready = 1'b0;
    step(32'sh7FFF_FFFF, 1'b1, 1'b0);
    step(32'sd32768, 1'b1, 1'b0);
    step(32'sd65536, 1'b1, 1'b0);
    idle(2);
    chk("pre_rst_dv1", dv1, 1);
    chk("pre_rst_sat1", sat1, 1);
    chk("pre_rst_dv4", dv4, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_dv1", dv1, 0);
    chk("async_sat1", sat1, 0);
    chk("async_dout1", dout1, 0);
    chk("async_dv4", dv4, 0);
    chk("async_sat4", sat4, 0);
    #1 reset = 1'b1;
    exp_q.delete(); ph = 0; pops = 0; sel = 1'b1; dout_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 5; i <= 8; i++) step(32'(i * 32768), 1'b1, 1'b1);
    idle(3);
    chk("post_rst_pops", pops, 1);
    chk("post_rst_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
